// File: rtl/uart_rx_periph_pkg.sv
// Shared definitions for the UART receive peripheral.
// Holds the bus register addresses, CON register bit indices (also meant for a future
// transmit peripheral) and the receive FSM state encoding.
package uart_rx_periph_pkg;

   localparam logic [31:0] UartRxdAddr = 32'h4000_001C;
   localparam logic [31:0] UartConAddr = 32'h4000_0020;

   localparam int unsigned ConIrqEnBit    = 0;
   localparam int unsigned ConFrameErrBit = 1;
   localparam int unsigned ConOverrunBit  = 2;
   localparam int unsigned ConRxValidBit  = 3;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for received UART data.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   push, din   write strobe and byte; ignored when full unless a pop happens the same cycle
//   pop         read strobe; ignored when empty
//   dout        current head (first-word fall-through)
//   empty, full occupancy status
module uart_rx_fifo #(
   parameter int unsigned Depth = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int unsigned AddrW = $clog2(Depth);

   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AddrW:0]   count_q, count_d;
   logic [7:0]       mem_q [Depth];
   logic             wr_en, rd_en;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AddrW + 1)'(Depth));
   assign rd_en = pop & ~empty;
   // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
   assign wr_en = push & (~full | rd_en);
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AddrW'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (AddrW + 1)'(1);
         2'b01:   count_d = count_q - (AddrW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_rx_periph.sv
// Memory-mapped UART receiver: 8N1, 16x oversampling, small receive FIFO.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx                  serial input, idle high, asynchronous to clk
//   addr, MemRead       bus read address/strobe; rdata is combinational from these
//   MemWrite, wdata     bus write strobe/data (only CON is writable)
//   rdata               bus read data
//   irq                 registered level interrupt
module uart_rx_periph
   import uart_rx_periph_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx,
   input  logic [31:0] addr,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam int unsigned OsrDiv = CLK_HZ / (BAUD * 16);
   localparam int unsigned TickW  = (OsrDiv > 1) ? $clog2(OsrDiv) : 1;

   logic             rx_meta_q, rx_sync_q;
   logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
   logic             tick;
   rx_state_e        state_q, state_d;
   logic [3:0]       s_cnt_q, s_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             byte_ok, byte_bad;
   logic             irq_en_q, irq_en_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             irq_d;
   logic             sel_rxd, sel_con, pop, wr_con, ovf_set;
   logic             fifo_empty, fifo_full;
   logic [7:0]       fifo_dout;
   logic             unused_wdata;

   assign unused_wdata = ^wdata[31:3];

   // Free-running oversample tick; never re-phased to the start edge.
   assign tick       = (tick_cnt_q == TickW'(OsrDiv - 1));
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);

   always_comb begin
      state_d   = state_q;
      s_cnt_d   = s_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      byte_ok   = 1'b0;
      byte_bad  = 1'b0;
      if (tick) begin
         s_cnt_d = s_cnt_q + 4'd1;
         unique case (state_q)
            StIdle: begin
               if (!rx_sync_q) begin
                  state_d = StStart;
                  s_cnt_d = '0;
               end
            end
            StStart: begin
               // Mid start bit: still low means a real frame, else a glitch.
               if (s_cnt_q == 4'd7) begin
                  s_cnt_d   = '0;
                  bit_cnt_d = '0;
                  state_d   = rx_sync_q ? StIdle : StData;
               end
            end
            StData: begin
               if (s_cnt_q == 4'd15) begin
                  shift_d   = {rx_sync_q, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_d = StStop;
               end
            end
            StStop: begin
               if (s_cnt_q == 4'd15) begin
                  byte_ok  = rx_sync_q;
                  byte_bad = ~rx_sync_q;
                  state_d  = StIdle;
               end
            end
         endcase
      end
   end

   assign sel_rxd = (addr == UartRxdAddr);
   assign sel_con = (addr == UartConAddr);
   assign pop     = MemRead & sel_rxd & ~fifo_empty;
   assign wr_con  = MemWrite & sel_con;
   assign ovf_set = byte_ok & fifo_full & ~pop;

   uart_rx_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (byte_ok),
      .din   (shift_q),
      .pop   (pop),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Clears are applied first so a same-cycle hardware set wins.
   always_comb begin
      irq_en_d    = irq_en_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
      if (wr_con) begin
         irq_en_d = wdata[ConIrqEnBit];
         if (wdata[ConFrameErrBit]) frame_err_d = 1'b0;
         if (wdata[ConOverrunBit])  overrun_d   = 1'b0;
      end
      if (byte_bad) frame_err_d = 1'b1;
      if (ovf_set)  overrun_d   = 1'b1;
      irq_d = irq_en_q & (~fifo_empty | frame_err_q | overrun_q);
   end

   always_comb begin
      rdata = '0;
      if (MemRead) begin
         if (sel_rxd) begin
            rdata[7:0] = fifo_empty ? 8'h00 : fifo_dout;
         end else if (sel_con) begin
            rdata[ConIrqEnBit]    = irq_en_q;
            rdata[ConFrameErrBit] = frame_err_q;
            rdata[ConOverrunBit]  = overrun_q;
            rdata[ConRxValidBit]  = ~fifo_empty;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         tick_cnt_q  <= '0;
         state_q     <= StIdle;
         s_cnt_q     <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         irq_en_q    <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         irq         <= 1'b0;
      end else begin
         rx_meta_q   <= rx;
         rx_sync_q   <= rx_meta_q;
         tick_cnt_q  <= tick_cnt_d;
         state_q     <= state_d;
         s_cnt_q     <= s_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         irq_en_q    <= irq_en_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         irq         <= irq_d;
      end
   end

endmodule
